rr_mux8: RTL

8-to-1 round-robin multiplexer with valid/ready handshakes on every lane, plus a registered output stage. It is the gathering counterpart of the 1-to-8 demux. It merges eight producer lanes onto one shared stream. Each output beat carries a 3-bit lane index, so a downstream demux can steer the beat back to the matching lane. An optional burst lock lets one lane send several consecutive beats before the grant rotates.

---
 rtl/rr_mux8_if.sv | 31 +++
 rtl/rr_mux8.sv | 88 ++++++++
 2 files changed

// File: rtl/rr_mux8_if.sv
// rr_mux8_if: bundle of the eight producer lanes and the shared output stream
// of the round-robin gather mux.
//   in_data   : packed lane data, lane k at [k*DATA_W +: DATA_W]
//   in_valid  : per-lane valid
//   in_ready  : per-lane ready (one-hot or zero)
//   out_data  : data of the current output beat
//   out_sel   : lane index of the current output beat
//   out_valid : output beat valid
//   out_ready : downstream accept
// slave  = the mux itself, master = producers plus downstream consumer.
interface rr_mux8_if #(
    parameter int DATA_W = 8
);
    logic [8*DATA_W-1:0] in_data;
    logic [7:0]          in_valid;
    logic [7:0]          in_ready;
    logic [DATA_W-1:0]   out_data;
    logic [2:0]          out_sel;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/rr_mux8.sv
// rr_mux8: 8-to-1 round-robin gather mux with a registered output stage and
// an optional burst lock that lets one lane send up to BURST beats in a row.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : rr_mux8_if.slave (lane inputs, in_ready, output stream)
module rr_mux8 #(
    parameter int DATA_W = 8,
    parameter int BURST  = 1
) (
    input logic      clk,
    input logic      rst_n,
    rr_mux8_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t              state, state_nxt;
    logic [2:0]          last_grant;
    logic [3:0]          burst_cnt;
    logic [DATA_W-1:0]   data_q;
    logic [2:0]          sel_q;

    logic                load_en;
    logic                lock;
    logic                grant;
    logic [2:0]          scan_g;
    logic [2:0]          gnt;
    logic [DATA_W-1:0]   lane_data [8];

    always_comb begin
        for (int k = 0; k < 8; k++)
            lane_data[k] = bus.in_data[k*DATA_W +: DATA_W];
    end

    // The output register can take a new beat when it is empty or being drained.
    assign load_en = (state == EMPTY) || bus.out_ready;

    assign lock = (burst_cnt != 4'd0) && (burst_cnt < 4'(BURST)) &&
                  bus.in_valid[last_grant];

    // Walk offsets 8 down to 1 so the nearest valid lane after last_grant
    // wins; offset 8 wraps to last_grant itself, which regrants a lone lane.
    always_comb begin
        scan_g = last_grant;
        for (int i = 8; i >= 1; i--) begin
            if (bus.in_valid[last_grant + 3'(i)])
                scan_g = last_grant + 3'(i);
        end
    end

    assign gnt   = lock ? last_grant : scan_g;
    // Gated by rst_n so no producer sees ready while the block is held in reset.
    assign grant = rst_n && load_en && (|bus.in_valid);

    assign bus.in_ready  = grant ? (8'b1 << gnt) : 8'h00;
    assign bus.out_valid = (state == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (grant) state_nxt = FULL;
            FULL:    if (load_en && !grant) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            data_q     <= '0;
            sel_q      <= 3'd0;
            last_grant <= 3'd7;
            burst_cnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                data_q     <= lane_data[gnt];
                sel_q      <= gnt;
                last_grant <= gnt;
                burst_cnt  <= lock ? burst_cnt + 4'd1 : 4'd1;
            end else if (load_en) begin
                // Output drains empty: data/sel keep their last values.
                burst_cnt <= 4'd0;
            end
        end
    end
endmodule
